// File: rtl/align_shift_64.sv
// align_shift_64
//   Two-stage pipelined 64-bit right-shift aligner with sticky-bit generation.
//   It aligns the smaller operand by an exponent difference ahead of the FP
//   adder, and also implements SRL/SRA for the integer path.
//
//   Stage 1 shifts by whole bytes (shamt[5:3]*8). Any shift of 64 or more
//   saturates to a full fill word. Stage 2 shifts by the remaining 0..7 bits.
//   Sticky is the OR of every original in_data bit that falls off the bottom.
//   Fill bits never contribute to sticky.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  a beat can be accepted this cycle
//   in_data    in   [DATA_W-1:0]  operand to shift right
//   in_shamt   in   [SHAMT_W-1:0] shift amount, 0..127
//   in_arith   in   1: fill with in_data[63]; 0: fill with zero
//   out_valid  out  output beat valid
//   out_ready  in   consumer accepts the output beat
//   out_data   out  [DATA_W-1:0]  shifted result
//   out_sticky out  OR of all non-fill bits shifted out
//   out_zero   out  out_data == 0
module align_shift_64 #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SHAMT_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sticky,
  output logic               out_zero
);

  localparam logic [DATA_W-1:0] ONES = '1;

  // Handshake control
  logic              rdy_en_q;
  logic              s1_load;
  logic              s2_load;

  // Stage 1 registers
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q,   s1_data_d;
  logic [2:0]        s1_fine_q,   s1_fine_d;
  logic              s1_fill_q,   s1_fill_d;
  logic              s1_sticky_q, s1_sticky_d;

  // Stage 2 registers (drive the outputs directly)
  logic              s2_valid_q;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic              out_sticky_q, out_sticky_d;
  logic              out_zero_q,   out_zero_d;

  // Stage-1 byte-aligned shift amount
  logic [5:0]        coarse_amt;
  logic              shamt_big;

  // in_ready is held low for the first cycle after reset release, then
  // depends only on pipeline occupancy and out_ready, never on in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_load  = rdy_en_q & (~s1_valid_q | s2_load);
  assign in_ready = s1_load;

  // Stage 1: coarse byte shift. Bits at or above position 64 of the shift
  // amount saturate the result to a full fill word with every data bit lost.
  always_comb begin
    shamt_big   = in_shamt[SHAMT_W-1];
    coarse_amt  = {in_shamt[5:3], 3'b000};
    s1_fill_d   = in_arith & in_data[DATA_W-1];
    s1_data_d   = '0;
    s1_fine_d   = '0;
    s1_sticky_d = 1'b0;
    if (shamt_big) begin
      s1_data_d   = {DATA_W{s1_fill_d}};
      s1_fine_d   = '0;
      s1_sticky_d = |in_data;
    end else begin
      s1_data_d   = (in_data >> coarse_amt)
                  | ({DATA_W{s1_fill_d}} & ~(ONES >> coarse_amt));
      s1_fine_d   = in_shamt[2:0];
      s1_sticky_d = |(in_data & ~(ONES << coarse_amt));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_fine_q   <= '0;
      s1_fill_q   <= 1'b0;
      s1_sticky_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q   <= s1_data_d;
        s1_fine_q   <= s1_fine_d;
        s1_fill_q   <= s1_fill_d;
        s1_sticky_q <= s1_sticky_d;
      end
    end
  end

  // Stage 2: fine shift by 0..7. The low bits of the stage-1 word are still
  // original data bits (at most 56+6 < 64), so they feed sticky directly.
  always_comb begin
    out_data_d   = (s1_data_q >> s1_fine_q)
                 | ({DATA_W{s1_fill_q}} & ~(ONES >> s1_fine_q));
    out_sticky_d = s1_sticky_q | (|(s1_data_q & ~(ONES << s1_fine_q)));
    out_zero_d   = ~|out_data_d;
  end

  // Payload only updates on a real beat so an empty pipeline keeps the last
  // result on out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= out_data_d;
        out_sticky_q <= out_sticky_d;
        out_zero_q   <= out_zero_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;
  assign out_sticky = out_sticky_q;
  assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_align_shift_64.sv
module tb_align_shift_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [6:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sticky;
  logic        out_zero;

  int n_chk  = 0;
  int n_fail = 0;

  align_shift_64 #(.DATA_W(64), .SHAMT_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_arith   (in_arith),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  shamt;
    logic        arith;
    logic [63:0] exp_data;
    logic        exp_sticky;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        sticky;
    logic        zero;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Straight-line reference: one full-width shift, no byte/bit split.
  function automatic exp_t ref_shift(input logic [63:0] d, input int unsigned sh, input logic ar);
    exp_t r;
    logic fill;
    fill = ar & d[63];
    if (sh >= 64) begin
      r.data   = {64{fill}};
      r.sticky = |d;
    end else begin
      r.data   = d;
      r.sticky = 1'b0;
      for (int unsigned i = 0; i < sh; i++) begin
        r.sticky = r.sticky | r.data[0];
        r.data   = {fill, r.data[63:1]};
      end
    end
    r.zero = (r.data == 64'h0);
    return r;
  endfunction

  task automatic apply_vec(input int idx);
    int edges;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = vecs[idx].data;
    in_shamt  = vecs[idx].shamt;
    in_arith  = vecs[idx].arith;
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    chk($sformatf("v%0d_latency", idx), 64'(edges), 64'd2);
    chk($sformatf("v%0d_data", idx), out_data, vecs[idx].exp_data);
    chk($sformatf("v%0d_sticky", idx), {63'b0, out_sticky}, {63'b0, vecs[idx].exp_sticky});
    chk($sformatf("v%0d_zero", idx), {63'b0, out_zero}, {63'b0, vecs[idx].exp_zero});
  endtask

  initial begin
    logic [63:0] bd[6];
    logic [6:0]  bs[6];
    logic        ba[6];
    int          acc, outs, ghost;
    logic [63:0] prev_data;
    logic        prev_stall, saw_block;
    exp_t        e, got;

    vecs[0]  = '{64'h8000_0000_0000_0000, 7'd63,  1'b0, 64'h0000_0000_0000_0001, 1'b0, 1'b0};
    vecs[1]  = '{64'h0000_0000_0000_00FF, 7'd4,   1'b0, 64'h0000_0000_0000_000F, 1'b1, 1'b0};
    vecs[2]  = '{64'h0000_0000_0000_00FF, 7'd0,   1'b0, 64'h0000_0000_0000_00FF, 1'b0, 1'b0};
    vecs[3]  = '{64'h0000_0000_0000_0001, 7'd64,  1'b0, 64'h0,                   1'b1, 1'b1};
    vecs[4]  = '{64'h0,                   7'd127, 1'b0, 64'h0,                   1'b0, 1'b1};
    vecs[5]  = '{64'hF000_0000_0000_0000, 7'd4,   1'b1, 64'hFF00_0000_0000_0000, 1'b0, 1'b0};
    vecs[6]  = '{64'hF000_0000_0000_0000, 7'd100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{64'hF000_0000_0000_0000, 7'd4,   1'b0, 64'h0F00_0000_0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{64'h8000_0000_0000_0001, 7'd64,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[9]  = '{64'h0123_4567_89AB_CDEF, 7'd8,   1'b0, 64'h0001_2345_6789_ABCD, 1'b1, 1'b0};
    vecs[10] = '{64'h0000_0000_0000_0100, 7'd8,   1'b0, 64'h0000_0000_0000_0001, 1'b0, 1'b0};
    vecs[11] = '{64'h0000_0000_0000_0080, 7'd8,   1'b1, 64'h0,                   1'b1, 1'b1};
    vecs[12] = '{64'h8000_0000_0000_0000, 7'd63,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[13] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd65,  1'b0, 64'h0,                   1'b1, 1'b1};
    vecs[14] = '{64'h1234_0000_0000_0000, 7'd12,  1'b0, 64'h0001_2340_0000_0000, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid",  {63'b0, out_valid},  64'd0);
    chk("rst_out_data",   out_data,            64'd0);
    chk("rst_out_sticky", {63'b0, out_sticky}, 64'd0);
    chk("rst_out_zero",   {63'b0, out_zero},   64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Directed table
    for (int i = 0; i < 15; i++) apply_vec(i);

    // Streaming with stall on cycles 3..6
    for (int i = 0; i < 6; i++) begin
      bd[i] = {$urandom, $urandom};
      bs[i] = 7'($urandom_range(0, 127));
      ba[i] = 1'($urandom_range(0, 1));
    end
    acc = 0; outs = 0; prev_stall = 1'b0; saw_block = 1'b0; prev_data = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid", {63'b0, out_valid}, 64'd1);
        chk("stall_hold", out_data, prev_data);
      end
      out_ready = !(k >= 3 && k <= 6);
      if (acc < 6) begin
        in_valid = 1'b1; in_data = bd[acc]; in_shamt = bs[acc]; in_arith = ba[acc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (sb.size() == 2 && !out_ready) begin
        chk("full_in_ready", {63'b0, in_ready}, 64'd0);
        saw_block = 1'b1;
      end
      if (k >= 7 && outs < 6) chk("throughput", {63'b0, out_valid}, 64'd1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          got.data = out_data; got.sticky = out_sticky; got.zero = out_zero;
          chk($sformatf("stream%0d_data", outs), got.data, e.data);
          chk($sformatf("stream%0d_sticky", outs), {63'b0, got.sticky}, {63'b0, e.sticky});
          chk($sformatf("stream%0d_zero", outs), {63'b0, got.zero}, {63'b0, e.zero});
        end
        outs++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_shift(in_data, int'(in_shamt), in_arith));
        acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (outs == 6) break;
    end
    chk("stream_count", 64'(outs), 64'd6);
    chk("stream_blocked", {63'b0, saw_block}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;

    // Mid-stream asynchronous reset with two beats in flight
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_1234; in_shamt = 7'd5; in_arith = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_data = 64'h0F0F_0F0F_0F0F_0F0F; in_shamt = 7'd9;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid",  {63'b0, out_valid},  64'd0);
    chk("async_rst_data",   out_data,            64'd0);
    chk("async_rst_sticky", {63'b0, out_sticky}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    ghost = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("rerst_in_ready", {63'b0, in_ready}, 64'd1);
      if (out_valid) ghost++;
    end
    chk("no_ghost_beats", 64'(ghost), 64'd0);
    apply_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
